// File: rtl/sys_cmd_master.sv
// sys_cmd_master: host-side initiator for the system controller's UART command protocol.
// Takes one request, serializes it as a command frame onto a UART TX byte stream,
// then collects the response bytes from UART RX and reports completion or timeout.
//
// Frames:  RF write  AA addr wdata
//          RF read   BB addr          -> 1 response byte
//          ALU op    CC A B fun       -> 2 response bytes (low first)
//          ALU nop   DD fun           -> 2 response bytes (low first)
//
// Optional build macro CMD_MASTER_STATS_EN adds saturating completion/timeout counters
// (STAT_DONE_CNT, STAT_TO_CNT) with a synchronous clear input (STAT_CLR).
module sys_cmd_master #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ALU_OUT_WIDTH = 16,
  parameter int unsigned RESP_TIMEOUT  = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  // Request side
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [1:0]               REQ_CMD,
  input  logic [ADDR_WIDTH-1:0]    REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]    REQ_WDATA,
  input  logic [DATA_WIDTH-1:0]    REQ_OPER_A,
  input  logic [DATA_WIDTH-1:0]    REQ_OPER_B,
  input  logic [3:0]               REQ_FUN,
  // UART TX byte interface
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     TX_BUSY,
  // UART RX byte interface
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  // Response side
  output logic [ALU_OUT_WIDTH-1:0] RSP_DATA,
  output logic                     RSP_VALID,
  output logic                     RSP_TIMEOUT,
  output logic                     BUSY
`ifdef CMD_MASTER_STATS_EN
  ,
  input  logic                     STAT_CLR,
  output logic [7:0]               STAT_DONE_CNT,
  output logic [7:0]               STAT_TO_CNT
`endif
);

  // Request command encodings
  localparam logic [1:0] CmdRfWr   = 2'b00;
  localparam logic [1:0] CmdRfRd   = 2'b01;
  localparam logic [1:0] CmdAluOp  = 2'b10;
  localparam logic [1:0] CmdAluNop = 2'b11;

  // Frame header bytes
  localparam logic [DATA_WIDTH-1:0] HdrRfWr   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] HdrRfRd   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] HdrAluOp  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] HdrAluNop = DATA_WIDTH'(8'hDD);

  // Timeout fires in the RX_WAIT cycle whose idle increment would reach RESP_TIMEOUT
  localparam logic [15:0] TimeoutLast = 16'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StTxByte,
    StRxWait,
    StComplete
  } state_e;

  state_e                   state_q;

  // Captured request
  logic [1:0]               cmd_q;
  logic [DATA_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    oper_a_q;
  logic [DATA_WIDTH-1:0]    oper_b_q;
  logic [DATA_WIDTH-1:0]    fun_q;

  // Transmit / receive progress
  logic [1:0]               tx_idx_q;
  logic [DATA_WIDTH-1:0]    tx_data_q;
  logic                     tx_vld_q;
  logic                     rx_got_q;
  logic [15:0]              to_cnt_q;

  // Registered response outputs
  logic [ALU_OUT_WIDTH-1:0] rsp_data_q;
  logic                     rsp_valid_q;
  logic                     rsp_timeout_q;

  // Combinational helpers
  logic [DATA_WIDTH-1:0]    hdr_sel;
  logic [1:0]               last_idx;
  logic [1:0]               next_idx;
  logic [DATA_WIDTH-1:0]    next_byte;
  logic                     tx_take;
  logic                     tx_last;
  logic                     rx_final;

  // Header byte for an incoming request
  always_comb begin
    hdr_sel = HdrRfWr;
    unique case (REQ_CMD)
      CmdRfWr:   hdr_sel = HdrRfWr;
      CmdRfRd:   hdr_sel = HdrRfRd;
      CmdAluOp:  hdr_sel = HdrAluOp;
      CmdAluNop: hdr_sel = HdrAluNop;
      default:   hdr_sel = HdrRfWr;
    endcase
  end

  // Index of the final frame byte for the captured command
  always_comb begin
    last_idx = 2'd1;
    unique case (cmd_q)
      CmdRfWr:   last_idx = 2'd2;
      CmdRfRd:   last_idx = 2'd1;
      CmdAluOp:  last_idx = 2'd3;
      CmdAluNop: last_idx = 2'd1;
      default:   last_idx = 2'd1;
    endcase
  end

  // Payload byte following the one currently on the TX interface
  always_comb begin
    next_idx  = tx_idx_q + 2'd1;
    next_byte = '0;
    unique case (cmd_q)
      CmdRfWr:   next_byte = (next_idx == 2'd1) ? addr_q : wdata_q;
      CmdRfRd:   next_byte = addr_q;
      CmdAluOp: begin
        unique case (next_idx)
          2'd1:    next_byte = oper_a_q;
          2'd2:    next_byte = oper_b_q;
          default: next_byte = fun_q;
        endcase
      end
      CmdAluNop: next_byte = fun_q;
      default:   next_byte = '0;
    endcase
  end

  // Handshake and progress decodes
  always_comb begin
    tx_take  = tx_vld_q && !TX_BUSY;
    tx_last  = (tx_idx_q == last_idx);
    // RF read needs one byte; ALU commands need a second
    rx_final = rx_got_q || (cmd_q == CmdRfRd);
  end

  // Main sequencer: request capture, frame transmission, response collection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StIdle;
      cmd_q         <= CmdRfWr;
      addr_q        <= '0;
      wdata_q       <= '0;
      oper_a_q      <= '0;
      oper_b_q      <= '0;
      fun_q         <= '0;
      tx_idx_q      <= 2'd0;
      tx_data_q     <= '0;
      tx_vld_q      <= 1'b0;
      rx_got_q      <= 1'b0;
      to_cnt_q      <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (REQ_VALID) begin
            cmd_q      <= REQ_CMD;
            addr_q     <= DATA_WIDTH'(REQ_ADDR);
            wdata_q    <= REQ_WDATA;
            oper_a_q   <= REQ_OPER_A;
            oper_b_q   <= REQ_OPER_B;
            fun_q      <= DATA_WIDTH'(REQ_FUN);
            tx_idx_q   <= 2'd0;
            tx_data_q  <= hdr_sel;
            tx_vld_q   <= 1'b1;
            rx_got_q   <= 1'b0;
            to_cnt_q   <= '0;
            // RF write reports zero; reads overwrite this as bytes arrive
            rsp_data_q <= '0;
            state_q    <= StTxByte;
          end
        end

        StTxByte: begin
          if (tx_take) begin
            if (tx_last) begin
              tx_vld_q <= 1'b0;
              to_cnt_q <= '0;
              rx_got_q <= 1'b0;
              if (cmd_q == CmdRfWr) begin
                rsp_valid_q <= 1'b1;
                state_q     <= StComplete;
              end else begin
                state_q     <= StRxWait;
              end
            end else begin
              tx_idx_q  <= next_idx;
              tx_data_q <= next_byte;
            end
          end
        end

        StRxWait: begin
          // A byte arriving on the would-be timeout cycle takes precedence
          if (RX_D_VLD) begin
            to_cnt_q <= '0;
            if (!rx_got_q) begin
              rsp_data_q <= ALU_OUT_WIDTH'(RX_P_DATA);
            end else begin
              rsp_data_q[ALU_OUT_WIDTH-1:DATA_WIDTH] <= RX_P_DATA;
            end
            if (rx_final) begin
              rsp_valid_q <= 1'b1;
              state_q     <= StComplete;
            end else begin
              rx_got_q    <= 1'b1;
            end
          end else if (to_cnt_q == TimeoutLast) begin
            rsp_timeout_q <= 1'b1;
            state_q       <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end

        StComplete: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output wiring from registered state
  always_comb begin
    REQ_READY   = (state_q == StIdle);
    BUSY        = (state_q != StIdle);
    TX_P_DATA   = tx_data_q;
    TX_D_VLD    = tx_vld_q;
    RSP_DATA    = rsp_data_q;
    RSP_VALID   = rsp_valid_q;
    RSP_TIMEOUT = rsp_timeout_q;
  end

`ifdef CMD_MASTER_STATS_EN
  logic [7:0] stat_done_q;
  logic [7:0] stat_to_q;

  // Saturating event counters; clear wins over a same-cycle increment
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stat_done_q <= 8'd0;
      stat_to_q   <= 8'd0;
    end else if (STAT_CLR) begin
      stat_done_q <= 8'd0;
      stat_to_q   <= 8'd0;
    end else begin
      if (rsp_valid_q && (stat_done_q != 8'hFF)) begin
        stat_done_q <= stat_done_q + 8'd1;
      end
      if (rsp_timeout_q && (stat_to_q != 8'hFF)) begin
        stat_to_q <= stat_to_q + 8'd1;
      end
    end
  end

  // Counter outputs
  always_comb begin
    STAT_DONE_CNT = stat_done_q;
    STAT_TO_CNT   = stat_to_q;
  end
`endif

endmodule

// File: tb/tb_sys_cmd_master.sv
// Bench for sys_cmd_master: table of directed transactions with hand-computed TX frames
// and responses, plus hand-written sequences for timeout, RX/timeout race and mid-frame reset.
module tb_sys_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, t_req_valid;
  logic [1:0]  req_cmd;
  logic [3:0]  req_addr;
  logic [7:0]  req_wdata, req_a, req_b;
  logic [3:0]  req_fun;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        stat_clr;

  logic        ready, busy, tx_vld, rsp_valid, rsp_to;
  logic [7:0]  tx_data;
  logic [15:0] rsp_data;
  logic        t_ready, t_busy, t_tx_vld, t_rsp_valid, t_rsp_to;
  logic [7:0]  t_tx_data;
  logic [15:0] t_rsp_data;
  logic [7:0]  done_cnt, to_cnt, t_done_cnt, t_to_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sys_cmd_master dut (
    .CLK(clk), .RST(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(ready), .REQ_CMD(req_cmd), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_OPER_A(req_a), .REQ_OPER_B(req_b), .REQ_FUN(req_fun),
    .TX_P_DATA(tx_data), .TX_D_VLD(tx_vld), .TX_BUSY(tx_busy),
    .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
    .RSP_DATA(rsp_data), .RSP_VALID(rsp_valid), .RSP_TIMEOUT(rsp_to), .BUSY(busy)
`ifdef CMD_MASTER_STATS_EN
    , .STAT_CLR(stat_clr), .STAT_DONE_CNT(done_cnt), .STAT_TO_CNT(to_cnt)
`endif
  );

  sys_cmd_master #(.RESP_TIMEOUT(8)) dut_to (
    .CLK(clk), .RST(rst_n),
    .REQ_VALID(t_req_valid), .REQ_READY(t_ready), .REQ_CMD(req_cmd), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_OPER_A(req_a), .REQ_OPER_B(req_b), .REQ_FUN(req_fun),
    .TX_P_DATA(t_tx_data), .TX_D_VLD(t_tx_vld), .TX_BUSY(tx_busy),
    .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
    .RSP_DATA(t_rsp_data), .RSP_VALID(t_rsp_valid), .RSP_TIMEOUT(t_rsp_to), .BUSY(t_busy)
`ifdef CMD_MASTER_STATS_EN
    , .STAT_CLR(stat_clr), .STAT_DONE_CNT(t_done_cnt), .STAT_TO_CNT(t_to_cnt)
`endif
  );

`ifndef CMD_MASTER_STATS_EN
  assign done_cnt   = 8'd0;
  assign to_cnt     = 8'd0;
  assign t_done_cnt = 8'd0;
  assign t_to_cnt   = 8'd0;
`endif

  typedef struct {
    logic [1:0]  cmd;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  fun;
    int          len;    // frame bytes
    logic [31:0] tx;     // expected frame, first byte in [31:24]
    int          nrx;    // response bytes
    logic [15:0] rx;     // first RX byte in [15:8]
    logic [15:0] rsp;    // expected RSP_DATA
    int          bsy;    // TX_BUSY cycles per byte
    int          dly;    // idle cycles before first RX byte
    bit          stray;  // RX strobe on the last TX consume cycle
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] d);
    rx_data = d;
    rx_vld  = 1'b1;
    tick();
    rx_vld  = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic set_req(input logic [1:0] c, input logic [3:0] ad, input logic [7:0] wd,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    req_cmd = c; req_addr = ad; req_wdata = wd; req_a = a; req_b = b; req_fun = f;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_to", {31'd0, rsp_to}, 32'd0);
  endtask

  // Full transaction on the main DUT, checking every TX byte and the response
  task automatic do_txn(input vec_t v);
    logic [7:0] eb;
    chk("idle_ready", {31'd0, ready}, 32'd1);
    set_req(v.cmd, v.addr, v.wdata, v.a, v.b, v.fun);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    // Request inputs must no longer matter
    set_req(~v.cmd, ~v.addr, ~v.wdata, ~v.a, ~v.b, ~v.fun);
    for (int i = 0; i < v.len; i++) begin
      eb = v.tx[31-8*i -: 8];
      chk("tx_vld", {31'd0, tx_vld}, 32'd1);
      chk("tx_byte", {24'd0, tx_data}, {24'd0, eb});
      chk("busy_tx", {31'd0, busy}, 32'd1);
      if (v.bsy > 0) begin
        tx_busy = 1'b1;
        for (int k = 0; k < v.bsy; k++) begin
          tick();
          chk("tx_hold_vld", {31'd0, tx_vld}, 32'd1);
          chk("tx_hold_byte", {24'd0, tx_data}, {24'd0, eb});
        end
        tx_busy = 1'b0;
      end
      if (v.stray && (i == v.len - 1)) rx_send(8'hEE);
      else tick();
    end
    chk("tx_vld_drop", {31'd0, tx_vld}, 32'd0);
    if (v.nrx > 0) begin
      chk("wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      repeat (v.dly) tick();
      chk("dly_no_rsp", {31'd0, rsp_valid | rsp_to}, 32'd0);
      rx_send(v.rx[15:8]);
      if (v.nrx == 2) begin
        chk("partial_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("partial_data", {16'd0, rsp_data}, {24'd0, v.rx[15:8]});
        tick();
        rx_send(v.rx[7:0]);
      end
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_data", {16'd0, rsp_data}, {16'd0, v.rsp});
    chk("rsp_no_to", {31'd0, rsp_to}, 32'd0);
    tick();
    chk("post_ready", {31'd0, ready}, 32'd1);
    chk("post_valid_low", {31'd0, rsp_valid}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  // Start a request on the timeout DUT and let its frame drain (TX_BUSY low)
  task automatic to_start(input logic [1:0] c, input logic [3:0] ad, input int len);
    set_req(c, ad, 8'h00, 8'h00, 8'h00, 4'h1);
    t_req_valid = 1'b1;
    tick();
    t_req_valid = 1'b0;
    repeat (len) tick();
    chk("to_tx_done", {31'd0, t_tx_vld}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; t_req_valid = 1'b0; tx_busy = 1'b0;
    rx_vld = 1'b0; rx_data = 8'h00; stat_clr = 1'b0;
    set_req(2'b00, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0);

    vecs[0] = '{cmd:2'b00, addr:4'h5, wdata:8'h3C, a:8'h00, b:8'h00, fun:4'h0, len:3,
                tx:32'hAA053C00, nrx:0, rx:16'h0000, rsp:16'h0000, bsy:0, dly:0, stray:1'b0};
    vecs[1] = '{cmd:2'b01, addr:4'h2, wdata:8'h00, a:8'h00, b:8'h00, fun:4'h0, len:2,
                tx:32'hBB020000, nrx:1, rx:16'h7E00, rsp:16'h007E, bsy:0, dly:20, stray:1'b0};
    vecs[2] = '{cmd:2'b10, addr:4'h0, wdata:8'h00, a:8'h12, b:8'h34, fun:4'h0, len:4,
                tx:32'hCC123400, nrx:2, rx:16'h4600, rsp:16'h0046, bsy:3, dly:2, stray:1'b0};
    vecs[3] = '{cmd:2'b11, addr:4'h0, wdata:8'h00, a:8'h00, b:8'h00, fun:4'h2, len:2,
                tx:32'hDD020000, nrx:2, rx:16'h1002, rsp:16'h0210, bsy:0, dly:1, stray:1'b1};
    vecs[4] = '{cmd:2'b00, addr:4'hF, wdata:8'hFF, a:8'h00, b:8'h00, fun:4'h0, len:3,
                tx:32'hAA0FFF00, nrx:0, rx:16'h0000, rsp:16'h0000, bsy:1, dly:0, stray:1'b1};
    vecs[5] = '{cmd:2'b01, addr:4'h0, wdata:8'h00, a:8'h00, b:8'h00, fun:4'h0, len:2,
                tx:32'hBB000000, nrx:1, rx:16'hA500, rsp:16'h00A5, bsy:0, dly:0, stray:1'b0};
    vecs[6] = '{cmd:2'b10, addr:4'h0, wdata:8'h00, a:8'hFF, b:8'h01, fun:4'hF, len:4,
                tx:32'hCCFF010F, nrx:2, rx:16'hFFFF, rsp:16'hFFFF, bsy:0, dly:0, stray:1'b0};

    tick();
    check_reset_outputs();
    chk("rst_t_ready", {31'd0, t_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    for (int n = 0; n < 7; n++) do_txn(vecs[n]);

`ifdef CMD_MASTER_STATS_EN
    chk("stat_done7", {24'd0, done_cnt}, 32'd7);
`endif

    // Reset after the second byte of a CC frame has been consumed
    set_req(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("mid_byte", {24'd0, tx_data}, 32'h34);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rx_send(8'h55);
      chk("no_stale_rsp", {31'd0, rsp_valid | rsp_to}, 32'd0);
    end
    do_txn(vecs[2]);

    // Timeout: RF read with no response, pulse after the 8th RX_WAIT cycle
    to_start(2'b01, 4'h3, 2);
    for (int k = 0; k < 8; k++) begin
      chk("to_wait", {30'd0, t_rsp_to, t_busy}, 32'd1);
      tick();
    end
    chk("to_pulse", {31'd0, t_rsp_to}, 32'd1);
    chk("to_no_valid", {31'd0, t_rsp_valid}, 32'd0);
    chk("to_ready", {31'd0, t_ready}, 32'd1);
    tick();
    chk("to_pulse_end", {31'd0, t_rsp_to}, 32'd0);
`ifdef CMD_MASTER_STATS_EN
    chk("stat_to1", {24'd0, t_to_cnt}, 32'd1);
`endif

    // RX byte on the would-be timeout cycle wins
    to_start(2'b01, 4'h4, 2);
    repeat (7) tick();
    rx_send(8'h5A);
    chk("race_valid", {30'd0, t_rsp_valid, t_rsp_to}, 32'd2);
    chk("race_data", {16'd0, t_rsp_data}, 32'h005A);
    tick();

    // Counter restarts on each byte: two bytes each arriving in the 8th cycle
    to_start(2'b11, 4'h0, 2);
    repeat (7) tick();
    rx_send(8'h21);
    repeat (7) tick();
    chk("clear_no_to", {31'd0, t_rsp_to}, 32'd0);
    rx_send(8'h43);
    chk("clear_valid", {30'd0, t_rsp_valid, t_rsp_to}, 32'd2);
    chk("clear_data", {16'd0, t_rsp_data}, 32'h4321);
    tick();

    // Timeout after one of two bytes keeps the partial result
    to_start(2'b10, 4'h0, 4);
    rx_send(8'h77);
    repeat (8) tick();
    chk("part_to", {30'd0, t_rsp_valid, t_rsp_to}, 32'd1);
    chk("part_data", {16'd0, t_rsp_data}, 32'h0077);
    tick();

`ifdef CMD_MASTER_STATS_EN
    chk("stat_to2", {24'd0, t_to_cnt}, 32'd2);
    chk("stat_done2", {24'd0, t_done_cnt}, 32'd2);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr", {16'd0, t_done_cnt, t_to_cnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
